// File: rtl/gb_host_arbiter.sv
// Two-host arbiter for a single ghostbus slave port: serialises A/B req/ack
// transactions into one-cycle wen/rstb strobes and returns captured read data.
module gb_host_arbiter #(
  parameter int AW          = 24,
  parameter int DW          = 32,
  parameter int RD_LAT      = 2,
  parameter int ROUND_ROBIN = 1
) (
  input  logic          gb_clk,
  input  logic          gb_rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata,
  output logic          busy,
  output logic          grant
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and latch the winner's request
  // ISSUE | one-cycle gb_wen or gb_rstb strobe
  // WAIT  | read latency countdown; gb_rdata captured when count hits 0
  // DONE  | one-cycle ack to the granted host
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("gb_host_arbiter: RD_LAT must be within 1..15");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] gb_addr_q, gb_addr_d;
  logic [DW-1:0] gb_wdata_q, gb_wdata_d;
  logic          we_q, we_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          win_b;

  always_comb begin
    state_d      = state_q;
    gb_addr_d    = gb_addr_q;
    gb_wdata_d   = gb_wdata_q;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    win_b        = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // last_grant resets to B, so A wins the first contention
          if (a_req && b_req) win_b = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b0;
          else                win_b = b_req;
          gb_addr_d    = win_b ? b_addr  : a_addr;
          gb_wdata_d   = win_b ? b_wdata : a_wdata;
          we_d         = win_b ? b_we    : a_we;
          grant_d      = win_b;
          last_grant_d = win_b;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = 4'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (grant_q) b_rdata_d = gb_rdata;
          else         a_rdata_d = gb_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state_q      <= IDLE;
      gb_addr_q    <= '0;
      gb_wdata_q   <= '0;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      gb_addr_q    <= gb_addr_d;
      gb_wdata_q   <= gb_wdata_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign gb_addr  = gb_addr_q;
  assign gb_wdata = gb_wdata_q;
  assign gb_wen   = (state_q == ISSUE) &&  we_q;
  assign gb_rstb  = (state_q == ISSUE) && !we_q;
  assign a_ack    = (state_q == DONE)  && !grant_q;
  assign b_ack    = (state_q == DONE)  &&  grant_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = (state_q != IDLE);
  assign grant    = grant_q;

endmodule

// File: tb/tb_gb_host_arbiter.sv
// Directed bench for gb_host_arbiter: three instances cover RR/RD_LAT=2,
// fixed-priority/RD_LAT=4 and RR/RD_LAT=1, each with a latency-accurate bus model.
module tb_gb_host_arbiter;

  logic        gb_clk = 1'b0;
  logic        gb_rst_n;
  logic [31:0] rd_val;

  logic        a_req [3], a_we [3], b_req [3], b_we [3];
  logic [23:0] a_addr [3], b_addr [3], gb_addr [3];
  logic [31:0] a_wdata [3], b_wdata [3], a_rdata [3], b_rdata [3];
  logic [31:0] gb_wdata [3], gb_rdata [3];
  logic        a_ack [3], b_ack [3], gb_wen [3], gb_rstb [3], busy [3], grant [3];

  int total = 0;
  int bad   = 0;

  always #5 gb_clk = ~gb_clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;
    localparam int RR  = (gi == 1) ? 0 : 1;
    logic [15:0] pipe;

    // bus returns rd_val only in the cycle LAT cycles after gb_rstb
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
      if (!gb_rst_n) pipe <= '0;
      else           pipe <= {pipe[14:0], gb_rstb[gi]};
    end
    assign gb_rdata[gi] = pipe[LAT-1] ? rd_val : 32'hBAD0_BAD0;

    gb_host_arbiter #(.AW(24), .DW(32), .RD_LAT(LAT), .ROUND_ROBIN(RR)) u_dut (
      .gb_clk   (gb_clk),
      .gb_rst_n (gb_rst_n),
      .a_req    (a_req[gi]),
      .a_we     (a_we[gi]),
      .a_addr   (a_addr[gi]),
      .a_wdata  (a_wdata[gi]),
      .a_ack    (a_ack[gi]),
      .a_rdata  (a_rdata[gi]),
      .b_req    (b_req[gi]),
      .b_we     (b_we[gi]),
      .b_addr   (b_addr[gi]),
      .b_wdata  (b_wdata[gi]),
      .b_ack    (b_ack[gi]),
      .b_rdata  (b_rdata[gi]),
      .gb_addr  (gb_addr[gi]),
      .gb_wdata (gb_wdata[gi]),
      .gb_wen   (gb_wen[gi]),
      .gb_rstb  (gb_rstb[gi]),
      .gb_rdata (gb_rdata[gi]),
      .busy     (busy[gi]),
      .grant    (grant[gi])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic wait_idle(input int d);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (a_ack[d]) a_req[d] = 1'b0;
      if (b_ack[d]) b_req[d] = 1'b0;
      if (!busy[d]) break;
    end
    chk("idle_reached", 64'(busy[d]), 64'd0);
  endtask

  // both hosts issue writes continuously; A gives up after a_limit acks
  task automatic contend(input int d, input int a_limit, input logic [3:0] exp_g);
    logic g [4];
    int   wc [4];
    int   n = 0, na = 0, both = 0;
    a_req[d] = 1'b1; a_we[d] = 1'b1; a_addr[d] = 24'h000100; a_wdata[d] = 32'hAAAA_0000;
    b_req[d] = 1'b1; b_we[d] = 1'b1; b_addr[d] = 24'h000200; b_wdata[d] = 32'hBBBB_0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (a_ack[d] && b_ack[d]) both++;
      if (a_ack[d]) begin
        na++;
        if (na >= a_limit) a_req[d] = 1'b0;
      end
      if (gb_wen[d] && n < 4) begin
        g[n]  = grant[d];
        wc[n] = k;
        chk("cont_addr", 64'(gb_addr[d]), exp_g[n] ? 64'h200 : 64'h100);
        n++;
      end
    end
    chk("cont_ngrants", 64'(n), 64'd4);
    for (int i = 0; i < n; i++) chk("cont_grant", 64'(g[i]), 64'(exp_g[i]));
    for (int i = 1; i < n; i++) chk("cont_spacing", 64'(wc[i] - wc[i-1]), 64'd3);
    chk("cont_both_acks", 64'(both), 64'd0);
    a_req[d] = 1'b0;
    b_req[d] = 1'b0;
    wait_idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, na, ack_k, idle_between;
    int rc [3];

    rd_val   = 32'h0;
    gb_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_req[i] = 0; a_we[i] = 0; a_addr[i] = '0; a_wdata[i] = '0;
      b_req[i] = 0; b_we[i] = 0; b_addr[i] = '0; b_wdata[i] = '0;
    end
    #1 gb_rst_n = 1'b0;
    tick();
    tick();
    chk("rst_gb_addr",  64'(gb_addr[0]),  64'd0);
    chk("rst_gb_wdata", 64'(gb_wdata[0]), 64'd0);
    chk("rst_gb_wen",   64'(gb_wen[0]),   64'd0);
    chk("rst_gb_rstb",  64'(gb_rstb[0]),  64'd0);
    chk("rst_acks",     64'({a_ack[0], b_ack[0]}), 64'd0);
    chk("rst_rdata",    {a_rdata[0], b_rdata[0]}, 64'd0);
    chk("rst_busy",     64'(busy[0]),  64'd0);
    chk("rst_grant",    64'(grant[0]), 64'd0);
    gb_rst_n = 1'b1;
    tick();

    // write from A
    a_req[0] = 1; a_we[0] = 1; a_addr[0] = 24'h000010; a_wdata[0] = 32'hDEAD_BEEF;
    chk("w_c0_busy", 64'(busy[0]), 64'd0);
    tick();
    chk("w_c1_wen",   64'(gb_wen[0]),   64'd1);
    chk("w_c1_rstb",  64'(gb_rstb[0]),  64'd0);
    chk("w_c1_addr",  64'(gb_addr[0]),  64'h10);
    chk("w_c1_wdata", 64'(gb_wdata[0]), 64'hDEAD_BEEF);
    chk("w_c1_grant", 64'(grant[0]),    64'd0);
    tick();
    chk("w_c2_ack",  64'({a_ack[0], b_ack[0]}), 64'b10);
    chk("w_c2_wen",  64'(gb_wen[0]), 64'd0);
    a_req[0] = 0;
    tick();
    chk("w_c3_busy", 64'(busy[0]), 64'd0);
    chk("w_c3_hold", 64'(gb_addr[0]), 64'h10);
    chk("w_c3_ack",  64'(a_ack[0]), 64'd0);

    // read from B, RD_LAT=2
    b_req[0] = 1; b_we[0] = 0; b_addr[0] = 24'h000020; rd_val = 32'h1234_5678;
    tick();
    chk("r_c1_rstb",  64'(gb_rstb[0]), 64'd1);
    chk("r_c1_wen",   64'(gb_wen[0]),  64'd0);
    chk("r_c1_grant", 64'(grant[0]),   64'd1);
    chk("r_c1_addr",  64'(gb_addr[0]), 64'h20);
    tick();
    chk("r_c2_busy", 64'(busy[0]), 64'd1);
    chk("r_c2_rstb", 64'(gb_rstb[0]), 64'd0);
    tick();
    chk("r_c3_ack", 64'(b_ack[0]), 64'd0);
    tick();
    chk("r_c4_ack",    64'({a_ack[0], b_ack[0]}), 64'b01);
    chk("r_c4_rdata",  64'(b_rdata[0]), 64'h1234_5678);
    chk("r_c4_a_hold", 64'(a_rdata[0]), 64'd0);
    b_req[0] = 0;
    tick();
    chk("r_c5_busy", 64'(busy[0]), 64'd0);

    // contention, round-robin: last grant was B, so A first
    contend(0, 99, 4'b1010);
    chk("wr_keeps_rdata", 64'(b_rdata[0]), 64'h1234_5678);

    // contention, fixed priority: A wins until it drops req
    contend(1, 3, 4'b1000);

    // reset during WAIT of a read, RD_LAT=4
    a_req[1] = 1; a_we[1] = 0; a_addr[1] = 24'h000030; rd_val = 32'hCAFE_F00D;
    tick();
    chk("rr_c1_rstb", 64'(gb_rstb[1]), 64'd1);
    tick();
    tick();
    chk("rr_c3_busy", 64'(busy[1]), 64'd1);
    #2 gb_rst_n = 1'b0;
    #1;
    chk("rr_async_busy",  64'(busy[1]),    64'd0);
    chk("rr_async_addr",  64'(gb_addr[1]), 64'd0);
    chk("rr_async_grant", 64'(grant[1]),   64'd0);
    chk("rr_async_strb",  64'({gb_wen[1], gb_rstb[1], a_ack[1], b_ack[1]}), 64'd0);
    tick();
    chk("rr_in_rst_ack", 64'(a_ack[1]), 64'd0);
    gb_rst_n = 1'b1;
    nr = 0; na = 0; ack_k = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (gb_rstb[1]) begin
        nr++;
        chk("rr_re_addr", 64'(gb_addr[1]), 64'h30);
      end
      if (a_ack[1]) begin
        na++;
        ack_k = k;
        chk("rr_re_rdata", 64'(a_rdata[1]), 64'hCAFE_F00D);
        a_req[1] = 0;
      end
    end
    chk("rr_rstb_count", 64'(nr), 64'd1);
    chk("rr_ack_count",  64'(na), 64'd1);
    chk("rr_ack_cycle",  64'(ack_k), 64'd6);
    chk("rr_end_busy",   64'(busy[1]), 64'd0);

    // back-to-back reads from A, RD_LAT=1
    a_req[2] = 1; a_we[2] = 0; a_addr[2] = 24'h000040; rd_val = 32'h5A5A_1234;
    nr = 0; ack_k = 0; idle_between = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (gb_rstb[2] && nr < 3) begin
        rc[nr] = k;
        nr++;
      end
      if (!busy[2] && nr == 1) idle_between++;
      if (a_ack[2] && ack_k == 0) begin
        ack_k = k;
        chk("bb_rdata", 64'(a_rdata[2]), 64'h5A5A_1234);
      end
    end
    chk("bb_rstb_count", 64'(nr), 64'd3);
    if (nr == 3) begin
      chk("bb_gap1", 64'(rc[1] - rc[0]), 64'd4);
      chk("bb_gap2", 64'(rc[2] - rc[1]), 64'd4);
    end
    chk("bb_idle_between", 64'(idle_between), 64'd1);
    chk("bb_ack_cycle",    64'(ack_k), 64'd3);
    wait_idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
